// File: rtl/alu_operand_ctrl.sv
// alu_operand_ctrl: operand fetch/sequencing stage feeding a 16-bit AND/ADD alu
module alu_operand_ctrl #(
  parameter int bit_size  = 15,
  parameter int reg_count = 8,
  parameter int addr_w    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [1:0]          instr_op,
  input  logic [addr_w-1:0]   instr_rd,
  input  logic [addr_w-1:0]   instr_rs,
  input  logic [addr_w-1:0]   instr_rt,
  input  logic [bit_size:0]   instr_imm,
  output logic [bit_size:0]   alu_a,
  output logic [bit_size:0]   alu_b,
  output logic                ALUand,
  output logic                ALUadd,
  input  logic [bit_size:0]   alu_out,
  output logic                wb_valid,
  output logic [addr_w-1:0]   wb_addr,
  output logic [bit_size:0]   wb_data,
  output logic                busy,
  input  logic [addr_w-1:0]   dbg_addr,
  output logic [bit_size:0]   dbg_data
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
  localparam logic [1:0] op_and = 2'b00, op_add = 2'b01, op_loadi = 2'b10;
  state_t state, nxt;
  logic [1:0] op_q;
  logic [addr_w-1:0] rd_q, rs_q, rt_q;
  logic [bit_size:0] res_q;
  logic [bit_size:0] regs [reg_count];
  logic accept;
  assign instr_ready = state == IDLE;
  assign busy        = ~instr_ready;
  assign accept      = instr_valid & instr_ready;
  assign wb_valid    = state == WB;
  assign wb_addr     = rd_q;
  assign wb_data     = res_q;
  assign dbg_data    = regs[dbg_addr];
  // next-state: AND/ADD go through the alu, LOADI skips straight to write-back, NOP is dropped
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (accept) nxt = (instr_op == op_loadi) ? WB : (instr_op[1] ? IDLE : READ);
      READ: nxt = EXEC;
      EXEC: nxt = WB;
      WB:   nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  // datapath: latch instruction, drive alu operands/selects, capture result, write back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      rd_q   <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      res_q  <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      ALUand <= 1'b0;
      ALUadd <= 1'b0;
      for (int i = 0; i < reg_count; i++) regs[i] <= '0;
    end else begin
      if (accept) begin
        op_q <= instr_op;
        rd_q <= instr_rd;
        rs_q <= instr_rs;
        rt_q <= instr_rt;
        if (instr_op == op_loadi) res_q <= instr_imm;
      end
      if (state == READ) begin
        alu_a  <= regs[rs_q];
        alu_b  <= regs[rt_q];
        ALUand <= op_q == op_and;
        ALUadd <= op_q == op_add;
      end
      if (state == EXEC) res_q <= alu_out;
      if (state == WB) begin
        ALUand <= 1'b0;
        ALUadd <= 1'b0;
        if (rd_q != '0) regs[rd_q] <= res_q;
      end
    end
  end
endmodule

// File: tb/tb_alu_operand_ctrl.sv
// tb_alu_operand_ctrl: scoreboard bench with a high-level register-file model
module tb_alu_operand_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic instr_valid = 1'b0, instr_ready;
  logic [1:0] instr_op = '0;
  logic [2:0] instr_rd = '0, instr_rs = '0, instr_rt = '0;
  logic [15:0] instr_imm = '0, alu_a, alu_b, alu_out, wb_data, dbg_data;
  logic ALUand, ALUadd, wb_valid, busy;
  logic [2:0] wb_addr, dbg_addr = '0;

  typedef struct {logic [2:0] addr; logic [15:0] data; logic [1:0] op; int t; int lat;} exp_t;
  exp_t q[$];
  logic [15:0] model [8];
  int total = 0, bad = 0, cyc = 0, acc_issued = 0, acc_seen = 0;

  alu_operand_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
    .instr_imm(instr_imm), .alu_a(alu_a), .alu_b(alu_b), .ALUand(ALUand), .ALUadd(ALUadd),
    .alu_out(alu_out), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // behavioural alu downstream of the stage
  assign alu_out = ALUand ? (alu_a & alu_b) : ALUadd ? (alu_a + alu_b) : 16'h0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && instr_valid && instr_ready) acc_seen <= acc_seen + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every write-back pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (ALUand && ALUadd) chk("selects_onehot", {ALUand, ALUadd}, 2'b01);
      if (busy === instr_ready) chk("busy_vs_ready", busy, ~instr_ready);
      if (wb_valid) begin
        if (q.size() == 0) chk("unexpected_wb", wb_valid, 1'b0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("wb_addr", wb_addr, e.addr);
          chk("wb_data", wb_data, e.data);
          chk("wb_latency", cyc - e.t, e.lat);
          chk("wb_sel_and", ALUand, e.op == 2'b00);
          chk("wb_sel_add", ALUadd, e.op == 2'b01);
        end
      end
    end
  end

  // drive one instruction, wait for acceptance, predict its result from the model
  task automatic issue(input logic [1:0] op, input logic [2:0] rd, rs, rt,
                       input logic [15:0] imm, input bit abort = 1'b0);
    int n = 0;
    logic [15:0] a, b, v;
    exp_t e;
    instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt; instr_imm = imm;
    instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      chk("accept_timeout", instr_ready, 1'b1);
      instr_valid = 1'b0;
      return;
    end
    a = (rs == 0) ? 16'h0 : model[rs];
    b = (rt == 0) ? 16'h0 : model[rt];
    v = (op == 2'b00) ? (a & b) : (op == 2'b01) ? 16'((a + b) % 32'h10000) : imm;
    acc_issued++;
    if (op != 2'b11 && !abort) begin
      e.addr = rd; e.data = v; e.op = op; e.t = cyc; e.lat = (op == 2'b10) ? 1 : 3;
      q.push_back(e);
      if (rd != 0) model[rd] = v;
    end
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic dbg_check(input logic [2:0] addr);
    dbg_addr = addr;
    #1;
    chk($sformatf("dbg_r%0d", addr), dbg_data, (addr == 0) ? 16'h0 : model[addr]);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_sel", {ALUand, ALUadd}, 0);
    chk("rst_wb", {wb_valid, wb_addr, wb_data}, 0);
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    for (int i = 0; i < 8; i++) dbg_check(3'(i));
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", instr_ready, 1);
    // AND of two loaded immediates, selects checked in EXEC
    issue(2'b10, 3'd1, 3'd0, 3'd0, 16'h1234);
    issue(2'b10, 3'd2, 3'd0, 3'd0, 16'h00FF);
    issue(2'b00, 3'd3, 3'd1, 3'd2, 16'h0);
    @(negedge clk);
    chk("exec_and_sel", {ALUand, ALUadd}, 2'b10);
    drain();
    dbg_check(3'd3);
    chk("and_value", dbg_data, 16'h0034);
    // ADD wraps modulo 2^16
    issue(2'b10, 3'd1, 3'd0, 3'd0, 16'hFFFF);
    issue(2'b10, 3'd2, 3'd0, 3'd0, 16'h0002);
    issue(2'b01, 3'd4, 3'd1, 3'd2, 16'h0);
    drain();
    dbg_check(3'd4);
    chk("add_wrap", dbg_data, 16'h0001);
    // r0 stays zero even when written
    issue(2'b10, 3'd0, 3'd0, 3'd0, 16'h5555);
    drain();
    dbg_check(3'd0);
    issue(2'b01, 3'd5, 3'd0, 3'd0, 16'h0);
    drain();
    dbg_check(3'd5);
    // held valid while busy: NOP and LOADI each taken exactly once
    issue(2'b01, 3'd7, 3'd1, 3'd2, 16'h0);
    issue(2'b11, 3'd6, 3'd1, 3'd1, 16'hDEAD);
    issue(2'b10, 3'd6, 3'd0, 3'd0, 16'hBEEF);
    issue(2'b01, 3'd1, 3'd1, 3'd1, 16'h0);
    drain();
    chk("accept_count", acc_seen, acc_issued);
    for (int i = 0; i < 8; i++) dbg_check(3'(i));
    // randomized traffic
    for (int k = 0; k < 150; k++) begin
      issue(2'($urandom_range(3)), 3'($urandom_range(7)), 3'($urandom_range(7)),
            3'($urandom_range(7)), 16'($urandom));
      if ($urandom_range(3) == 0) @(negedge clk);
      if (k % 25 == 24) begin
        drain();
        dbg_check(3'($urandom_range(7)));
      end
    end
    drain();
    for (int i = 0; i < 8; i++) dbg_check(3'(i));
    chk("accept_count_rand", acc_seen, acc_issued);
    // reset during EXEC aborts the ADD
    issue(2'b10, 3'd1, 3'd0, 3'd0, 16'h0101);
    drain();
    issue(2'b01, 3'd6, 3'd1, 3'd1, 16'h0, 1'b1);
    @(negedge clk);
    chk("abort_in_exec", {ALUand, ALUadd}, 2'b01);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) model[i] = 16'h0;
    chk("abort_wb_valid", wb_valid, 0);
    chk("abort_ready", instr_ready, 1);
    chk("abort_sel", {ALUand, ALUadd}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    dbg_check(3'd6);
    dbg_check(3'd1);
    issue(2'b10, 3'd2, 3'd0, 3'd0, 16'h00AA);
    drain();
    dbg_check(3'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
